// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Bit counter width. It must hold WIDTH-1, so $clog2(WIDTH) is
    // enough. The floor of 1 keeps the counter legal for degenerate widths.
    function automatic int div_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   p_i       partial remainder before this step (always < divisor_i)
//   msb_i     dividend bit shifted into the partial remainder
//   divisor_i divisor
//   p_o       partial remainder after this step
//   qbit_o    quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] p_o,
    output logic             qbit_o
);

    // The shifted remainder can need WIDTH+1 bits, so the compare is done
    // one bit wider than the operands.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {p_i, msb_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        // When the subtract is taken, the true difference is below the
        // divisor. It therefore fits in WIDTH bits, and modulo-2^WIDTH
        // arithmetic on the low bits gives the exact result.
        diff    = shifted[WIDTH-1:0] - divisor_i;
        p_o     = qbit_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/tt_um_willyjules_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: WIDTH+1 cycles from accept to out_valid (1 cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (dividend, divisor)
//   out_valid/out_ready      result handshake (quotient, remainder, div_by_zero)
module tt_um_willyjules_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_cnt_width(WIDTH);

    div_state_e       state_q;
    // The dividend register does double duty. Dividend bits leave at the
    // MSB while quotient bits enter at the LSB. After WIDTH steps it holds
    // the quotient.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] p_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [WIDTH-1:0] step_p;
    logic             step_qbit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_i       (p_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .p_o       (step_p),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            // in_ready stays low for the reset cycle. It rises on the first
            // edge with rst low, so no accept can happen on that edge.
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dvd_q      <= dividend;
                        dvs_q      <= divisor;
                        p_q        <= '0;
                        cnt_q      <= CW'(WIDTH - 1);
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end

                RUN: begin
                    dvd_q <= {dvd_q[WIDTH-2:0], step_qbit};
                    p_q   <= step_p;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= {dvd_q[WIDTH-2:0], step_qbit};
                        remainder_q <= step_p;
                        dbz_q       <= 1'b0;
                    end
                end

                DONE: begin
                    // The result registers are left untouched so that the
                    // last result stays visible after it is consumed.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
